// File: rtl/cache_miss_arb_if.sv
// rtl/cache_miss_arb_if.sv - requester and miss-queue handshake bundle for cache_miss_arb
//
// Purpose: groups the requester-side and queue-side signals of the miss
// arbiter into one bundle so the arbiter and its environment share one port.
//
// Signals (names follow the arbiter's view of direction):
//   rvld_i  [NUM_REQ]            per-requester packet valid
//   rrdy_o  [NUM_REQ]            per-requester ready, one-hot or zero
//   rdat_i  [NUM_REQ*PKT_WIDTH]  packets, requester i at [i*PKT_WIDTH +: PKT_WIDTH]
//   rack_o  [NUM_REQ]            per-requester ack pulse
//   qvld_o                       queue valid
//   qrdy_i                       queue ready
//   qdat_o  [PKT_WIDTH]          queue packet
//   ack_i                        completion from the far side of the queue
//   err_o                        watchdog timeout pulse
//
// Modports:
//   slave  - the arbiter
//   master - the cache controllers / queue environment driving the arbiter
interface cache_miss_arb_if #(
  parameter int NUM_REQ   = 2,
  parameter int PKT_WIDTH = 37
);
  logic [NUM_REQ-1:0]           rvld_i;
  logic [NUM_REQ-1:0]           rrdy_o;
  logic [NUM_REQ*PKT_WIDTH-1:0] rdat_i;
  logic [NUM_REQ-1:0]           rack_o;
  logic                         qvld_o;
  logic                         qrdy_i;
  logic [PKT_WIDTH-1:0]         qdat_o;
  logic                         ack_i;
  logic                         err_o;

  modport slave (
    input  rvld_i, rdat_i, qrdy_i, ack_i,
    output rrdy_o, rack_o, qvld_o, qdat_o, err_o
  );

  modport master (
    output rvld_i, rdat_i, qrdy_i, ack_i,
    input  rrdy_o, rack_o, qvld_o, qdat_o, err_o
  );
endinterface

// File: rtl/cache_miss_arb.sv
// rtl/cache_miss_arb.sv - round-robin arbiter sharing one miss/flush queue between cache controllers
//
// Purpose: accepts one miss packet at a time from up to NUM_REQ cache
// controller FSMs, forwards it onto the downstream async queue, holds
// ownership until the far side returns ack_i, then pulses rack_o to the
// owning requester and advances the round-robin pointer past it.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - asynchronous, active-low reset
//   bus    - cache_miss_arb_if.slave: rvld_i/rrdy_o/rdat_i/rack_o toward the
//            requesters, qvld_o/qrdy_i/qdat_o/ack_i toward the queue, err_o
//
// Parameters:
//   NUM_REQ        - number of requesters, 2..8
//   PKT_WIDTH      - packet width (flush + way bits + address)
//   TIMEOUT_CYCLES - ack watchdog limit in WAIT cycles
//
// Optional feature: define CACHE_ARB_TIMEOUT_EN to build the ack watchdog.
// Without it err_o is tied 0 and WAIT waits for ack_i indefinitely.
module cache_miss_arb #(
  parameter int NUM_REQ        = 2,
  parameter int PKT_WIDTH      = 37,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  cache_miss_arb_if.slave  bus
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic [GW-1:0] LAST_REQ = GW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cache_miss_arb: parameter out of range");
  end

  logic [1:0]           state;
  logic [GW-1:0]        ptr;
  logic [GW-1:0]        grant_r;
  logic [GW-1:0]        win;
  logic                 win_vld;
  logic [NUM_REQ-1:0]   rrdy;
  logic                 qvld_r;
  logic [PKT_WIDTH-1:0] qdat_r;
  logic [NUM_REQ-1:0]   rack_r;
  logic                 timeout_hit;
  logic                 wait_done;

  // Per-requester packet view so the winner selects a whole slot.
  logic [PKT_WIDTH-1:0] pkt [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pkt
    assign pkt[i] = bus.rdat_i[i*PKT_WIDTH +: PKT_WIDTH];
  end

  // Round-robin search starting at ptr. Walking the offsets from the far end
  // down to zero lets the nearest asserted requester overwrite the others,
  // which gives first-match priority without a loop break.
  always_comb begin
    int          idx;
    logic [GW-1:0] idx_w;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_w = GW'(idx);
      if (bus.rvld_i[idx_w]) begin
        win     = idx_w;
        win_vld = 1'b1;
      end
    end
  end

  // Ready is offered only in IDLE and is held low while reset is asserted,
  // since the arbitration itself is purely combinational.
  always_comb begin
    rrdy = '0;
    if (reset && (state == ST_IDLE) && win_vld) begin
      rrdy[win] = 1'b1;
    end
  end

  // WAIT finishes on a real ack, or on the watchdog's terminal cycle.
  assign wait_done = (state == ST_WAIT) && (bus.ack_i || timeout_hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      grant_r <= '0;
      qvld_r  <= 1'b0;
      qdat_r  <= '0;
      rack_r  <= '0;
    end else begin
      rack_r <= '0;
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            grant_r <= win;
            qdat_r  <= pkt[win];
            qvld_r  <= 1'b1;
            state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          // ack_i is deliberately not looked at here, even on the beat.
          if (bus.qrdy_i) begin
            qvld_r <= 1'b0;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_done) begin
            rack_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_r;
            ptr    <= (grant_r == LAST_REQ) ? '0 : grant_r + 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt;
  logic          err_r;

  // wait_cnt holds the number of ack-less WAIT cycles already seen, so the
  // TIMEOUT_CYCLES-th such cycle is the terminal one. An ack on that cycle
  // wins because timeout_hit requires ack_i low.
  assign timeout_hit = (state == ST_WAIT) && !bus.ack_i &&
                       (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      err_r    <= 1'b0;
    end else begin
      err_r <= timeout_hit;
      if ((state == ST_SEND) && bus.qrdy_i) begin
        wait_cnt <= '0;
      end else if ((state == ST_WAIT) && !bus.ack_i && !timeout_hit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign bus.err_o = err_r;
`else
  assign timeout_hit = 1'b0;
  assign bus.err_o   = 1'b0;
`endif

  assign bus.rrdy_o = rrdy;
  assign bus.rack_o = rack_r;
  assign bus.qvld_o = qvld_r;
  assign bus.qdat_o = qdat_r;

endmodule

// File: tb/tb_cache_miss_arb.sv
// tb/tb_cache_miss_arb.sv - self-checking bench for cache_miss_arb
module tb_cache_miss_arb;

  localparam int N  = 2;
  localparam int W  = 37;
  localparam int TO = 8;

  localparam logic [W-1:0] Z  = '0;
  localparam logic [W-1:0] K  = 37'h0_0000_1000;
  localparam logic [W-1:0] A  = 37'h0_0000_000A;
  localparam logic [W-1:0] B  = 37'h0_0000_000B;
  localparam logic [W-1:0] P  = 37'h1_2345_6789;
  localparam logic [W-1:0] Q  = 37'h0_0000_0055;
  localparam logic [W-1:0] R  = 37'h0_0000_0077;
  localparam logic [W-1:0] T  = 37'h1_F00D_CAFE;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_miss_arb_if #(.NUM_REQ(N), .PKT_WIDTH(W)) bus ();

  cache_miss_arb #(
    .NUM_REQ       (N),
    .PKT_WIDTH     (W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         rst;
    logic [N-1:0] rvld;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         qrdy;
    logic         ack;
    logic [N-1:0] e_rrdy;
    logic         e_qvld;
    logic [W-1:0] e_qdat;
    logic [N-1:0] e_rack;
    logic         e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic rst, logic [N-1:0] rvld, logic [W-1:0] d0,
                              logic [W-1:0] d1, logic qrdy, logic ack,
                              logic [N-1:0] e_rrdy, logic e_qvld, logic [W-1:0] e_qdat,
                              logic [N-1:0] e_rack, logic e_err);
    tbl.push_back('{rst, rvld, d0, d1, qrdy, ack, e_rrdy, e_qvld, e_qdat, e_rack, e_err});
  endfunction

  task automatic drive(logic rst, logic [N-1:0] rvld, logic [W-1:0] d0, logic [W-1:0] d1,
                       logic qrdy, logic ack);
    reset       = rst;
    bus.rvld_i  = rvld;
    bus.rdat_i  = {d1, d0};
    bus.qrdy_i  = qrdy;
    bus.ack_i   = ack;
  endtask

  task automatic check_all(string tag, logic [N-1:0] e_rrdy, logic e_qvld,
                           logic [W-1:0] e_qdat, logic [N-1:0] e_rack, logic e_err);
    checks += 5;
    if (bus.rrdy_o !== e_rrdy) begin
      errors++;
      $display("FAIL %s rrdy_o: got %b expected %b", tag, bus.rrdy_o, e_rrdy);
    end
    if (bus.qvld_o !== e_qvld) begin
      errors++;
      $display("FAIL %s qvld_o: got %b expected %b", tag, bus.qvld_o, e_qvld);
    end
    if (bus.qdat_o !== e_qdat) begin
      errors++;
      $display("FAIL %s qdat_o: got %h expected %h", tag, bus.qdat_o, e_qdat);
    end
    if (bus.rack_o !== e_rack) begin
      errors++;
      $display("FAIL %s rack_o: got %b expected %b", tag, bus.rack_o, e_rack);
    end
    if (bus.err_o !== e_err) begin
      errors++;
      $display("FAIL %s err_o: got %b expected %b", tag, bus.err_o, e_err);
    end
  endtask

  // Reference model: a packet is either being offered on the queue or
  // awaiting its ack; otherwise the arbiter is free to pick a new owner.
  bit           m_offering;
  bit           m_awaiting;
  int           m_owner;
  int           m_ptr;
  int           m_waited;
  logic [W-1:0] m_qdat;
  logic [N-1:0] m_rack;
  logic         m_err;

  function automatic void model_reset();
    m_offering = 0;
    m_awaiting = 0;
    m_owner    = 0;
    m_ptr      = 0;
    m_waited   = 0;
    m_qdat     = '0;
    m_rack     = '0;
    m_err      = 1'b0;
  endfunction

  function automatic int model_pick(logic [N-1:0] rvld);
    for (int k = 0; k < N; k++) begin
      if (rvld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  initial begin
    logic [N-1:0] r_rvld;
    logic [W-1:0] r_d [N];
    logic         r_qrdy;
    logic         r_ack;
    logic         r_rst;
    logic [N-1:0] e_rrdy;
    int           pick;

    // cycle-by-cycle table from reset: single request, reset, contention,
    // backpressure with early acks, then reset in WAIT
    add(1, 2'b01, K, Z, 1, 0,  2'b01, 0, Z, 2'b00, 0);
    add(1, 2'b00, K, Z, 1, 0,  2'b00, 1, K, 2'b00, 0);
    add(1, 2'b00, K, Z, 1, 0,  2'b00, 0, K, 2'b00, 0);
    add(1, 2'b00, K, Z, 1, 0,  2'b00, 0, K, 2'b00, 0);
    add(1, 2'b00, K, Z, 1, 0,  2'b00, 0, K, 2'b00, 0);
    add(1, 2'b00, K, Z, 1, 1,  2'b00, 0, K, 2'b00, 0);
    add(1, 2'b00, K, Z, 1, 0,  2'b00, 0, K, 2'b01, 0);
    add(0, 2'b11, A, B, 1, 1,  2'b00, 0, Z, 2'b00, 0);
    add(1, 2'b11, A, B, 1, 1,  2'b01, 0, Z, 2'b00, 0);
    add(1, 2'b11, A, B, 1, 1,  2'b00, 1, A, 2'b00, 0);
    add(1, 2'b11, A, B, 1, 1,  2'b00, 0, A, 2'b00, 0);
    add(1, 2'b11, A, B, 1, 1,  2'b10, 0, A, 2'b01, 0);
    add(1, 2'b11, A, B, 1, 1,  2'b00, 1, B, 2'b00, 0);
    add(1, 2'b11, A, B, 1, 1,  2'b00, 0, B, 2'b00, 0);
    add(1, 2'b11, A, B, 1, 1,  2'b01, 0, B, 2'b10, 0);
    add(1, 2'b11, A, B, 1, 1,  2'b00, 1, A, 2'b00, 0);
    add(1, 2'b11, A, B, 1, 1,  2'b00, 0, A, 2'b00, 0);
    add(1, 2'b11, A, B, 1, 1,  2'b10, 0, A, 2'b01, 0);
    add(1, 2'b11, A, B, 1, 1,  2'b00, 1, B, 2'b00, 0);
    add(1, 2'b11, A, B, 1, 1,  2'b00, 0, B, 2'b00, 0);
    add(1, 2'b00, A, B, 1, 1,  2'b00, 0, B, 2'b10, 0);
    add(1, 2'b10, A, P, 0, 1,  2'b10, 0, B, 2'b00, 0);
    add(1, 2'b11, A, P, 0, 0,  2'b00, 1, P, 2'b00, 0);
    add(1, 2'b11, A, P, 0, 0,  2'b00, 1, P, 2'b00, 0);
    add(1, 2'b11, A, P, 0, 0,  2'b00, 1, P, 2'b00, 0);
    add(1, 2'b11, A, P, 0, 0,  2'b00, 1, P, 2'b00, 0);
    add(1, 2'b11, A, P, 1, 1,  2'b00, 1, P, 2'b00, 0);
    add(1, 2'b00, A, P, 0, 0,  2'b00, 0, P, 2'b00, 0);
    add(1, 2'b00, A, P, 0, 0,  2'b00, 0, P, 2'b00, 0);
    add(1, 2'b00, A, P, 0, 1,  2'b00, 0, P, 2'b00, 0);
    add(1, 2'b00, A, P, 0, 0,  2'b00, 0, P, 2'b10, 0);
    add(1, 2'b01, Q, R, 1, 0,  2'b01, 0, P, 2'b00, 0);
    add(1, 2'b00, Q, R, 1, 0,  2'b00, 1, Q, 2'b00, 0);
    add(1, 2'b00, Q, R, 1, 1,  2'b00, 0, Q, 2'b00, 0);
    add(1, 2'b10, Q, R, 1, 0,  2'b10, 0, Q, 2'b01, 0);
    add(1, 2'b00, Q, R, 1, 0,  2'b00, 1, R, 2'b00, 0);
    add(1, 2'b00, Q, R, 1, 0,  2'b00, 0, R, 2'b00, 0);
    add(0, 2'b11, Q, R, 1, 0,  2'b00, 0, Z, 2'b00, 0);
    add(1, 2'b00, Q, R, 1, 1,  2'b00, 0, Z, 2'b00, 0);
    add(1, 2'b00, Q, R, 1, 0,  2'b00, 0, Z, 2'b00, 0);
    add(1, 2'b11, A, R, 1, 0,  2'b01, 0, Z, 2'b00, 0);
    add(1, 2'b00, A, R, 1, 0,  2'b00, 1, A, 2'b00, 0);
    add(1, 2'b00, A, R, 1, 1,  2'b00, 0, A, 2'b00, 0);
    add(1, 2'b00, A, R, 1, 0,  2'b00, 0, A, 2'b01, 0);
    add(1, 2'b00, A, R, 1, 0,  2'b00, 0, A, 2'b00, 0);

    drive(0, '0, Z, Z, 0, 0);
    #1;
    check_all("reset", 2'b00, 0, Z, 2'b00, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].rvld, tbl[i].d0, tbl[i].d1, tbl[i].qrdy, tbl[i].ack);
      #1;
      check_all($sformatf("table[%0d]", i), tbl[i].e_rrdy, tbl[i].e_qvld, tbl[i].e_qdat,
                tbl[i].e_rack, tbl[i].e_err);
    end

    // watchdog: no ack after the queue beat
    @(negedge clk);
    drive(0, '0, Z, Z, 1, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drive(1, 2'b01, T, Z, 1, 0);
    #1;
    check_all("wd request", 2'b01, 0, Z, 2'b00, 0);
    @(negedge clk);
    drive(1, 2'b00, T, Z, 1, 0);
    #1;
    check_all("wd send", 2'b00, 1, T, 2'b00, 0);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      #1;
      check_all($sformatf("wd wait[%0d]", i), 2'b00, 0, T, 2'b00, 0);
    end
    @(negedge clk);
    #1;
`ifdef CACHE_ARB_TIMEOUT_EN
    check_all("wd expire", 2'b00, 0, T, 2'b01, 1);
    @(negedge clk);
    drive(1, 2'b10, T, Z, 1, 0);
    #1;
    check_all("wd idle", 2'b10, 0, T, 2'b00, 0);
`else
    check_all("wd no expire", 2'b00, 0, T, 2'b00, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1, 2'b10, T, Z, 1, 0);
      #1;
      check_all("wd still waiting", 2'b00, 0, T, 2'b00, 0);
    end
`endif

    // randomized traffic against the reference model
    @(negedge clk);
    drive(0, '0, Z, Z, 0, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      r_rst  = ($urandom_range(0, 99) != 0);
      r_rvld = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) r_d[i] = W'({$urandom(), $urandom()});
      r_qrdy = ($urandom_range(0, 1) == 1);
      r_ack  = ($urandom_range(0, 5) == 0);
      drive(r_rst, r_rvld, r_d[0], r_d[1], r_qrdy, r_ack);
      if (!r_rst) model_reset();
      pick   = -1;
      e_rrdy = '0;
      if (r_rst && !m_offering && !m_awaiting) begin
        pick = model_pick(r_rvld);
        if (pick >= 0) e_rrdy = N'(1) << pick;
      end
      #1;
      check_all($sformatf("random[%0d]", cyc), e_rrdy, m_offering, m_qdat, m_rack, m_err);

      if (r_rst) begin
        m_rack = '0;
        m_err  = 1'b0;
        if (m_offering) begin
          if (r_qrdy) begin
            m_offering = 0;
            m_awaiting = 1;
            m_waited   = 0;
          end
        end else if (m_awaiting) begin
          if (r_ack) begin
            m_rack     = N'(1) << m_owner;
            m_ptr      = (m_owner + 1) % N;
            m_awaiting = 0;
          end
`ifdef CACHE_ARB_TIMEOUT_EN
          else if (m_waited + 1 == TO) begin
            m_rack     = N'(1) << m_owner;
            m_err      = 1'b1;
            m_ptr      = (m_owner + 1) % N;
            m_awaiting = 0;
          end
`endif
          else begin
            m_waited++;
          end
        end else if (pick >= 0) begin
          m_owner    = pick;
          m_qdat     = r_d[pick];
          m_offering = 1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
